turn_sequencer: RTL and testbench
=================================

# turn_sequencer

Game-flow controller for the Chicken Cha-Cha-Cha board. It sequences each player's turn through tile reveal, match check, chicken move and miss display. It tracks which of the 12 hidden tiles are face-up in the current turn and emits the one-cycle turn-advance strobe. It sits between the button/tile-select front end and the board datapath (tile comparator, chicken-move and feather logic).

## Interface
- NUM_TILES, 12, number of hidden octagonal tiles
- SHOW_CYCLES, 25_000_000, cycles a mismatched tile stays visible before the turn passes (0.5 s at 50 MHz)
- TIMEOUT_CYCLES, 500_000_000, idle-flip timeout; used only with the timeout feature
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- num_players  in  3  player count, sampled on start; valid 2..4
- start  in  1  one-cycle pulse; begins a game from IDLE or DONE
- flip_req  in  1  one-cycle pulse; player selects a tile
- flip_idx  in  4  selected tile index 0..NUM_TILES-1
- match_valid  in  1  comparator result valid
- match  in  1  revealed tile matches the tile ahead of the current chicken
- move_done  in  1  one-cycle pulse; chicken move (including feather transfer) complete
- win  in  1  sampled with move_done; current player holds all feathers
- cur_player  out  2  active player 0..N-1
- reveal  out  1  one-cycle pulse; show tile reveal_idx
- reveal_idx  out  4  tile to reveal
- revealed  out  NUM_TILES  face-up mask for the current turn
- move_req  out  1  one-cycle pulse; advance current chicken
- hide_all  out  1  one-cycle pulse; turn all tiles face-down
- turn_pulse  out  1  one-cycle turn-advance strobe
- phase  out  3  FSM state code
- winner_valid  out  1  high in DONE
- winner  out  2  winning player

## Operation
- States and codes: IDLE=0, WAIT_FLIP=1, CHECK=2, MOVE=3, SHOW_MISS=4, ADVANCE=5, DONE=6.
- IDLE/DONE + start: latch N = num_players clamped to 2..4 (values <2 give 2, >4 give 4). Set cur_player=0, revealed=0, winner_valid=0. Go to WAIT_FLIP.
- WAIT_FLIP + flip_req:
  - Tile valid (flip_idx < NUM_TILES) and its revealed bit clear: reveal=1, reveal_idx=flip_idx, set the bit, go to CHECK.
  - Otherwise the request is ignored and the FSM stays in WAIT_FLIP.
- WAIT_FLIP with revealed all ones: go directly to ADVANCE.
- CHECK + match_valid:
  - match=1: move_req=1, go to MOVE.
  - match=0: load timer with SHOW_CYCLES, go to SHOW_MISS.
- MOVE + move_done:
  - win=1: winner=cur_player, winner_valid=1, go to DONE.
  - win=0: go to WAIT_FLIP. Same player continues; revealed is kept.
- SHOW_MISS: after exactly SHOW_CYCLES cycles, go to ADVANCE.
- ADVANCE (one cycle): hide_all=1, turn_pulse=1, revealed cleared. cur_player becomes (cur_player+1) mod N, wrapping from N-1 to 0. Go to WAIT_FLIP.
- flip_req, match_valid and move_done are ignored outside their consuming state. start is ignored outside IDLE/DONE.
- Reset values: all outputs 0, phase=IDLE, timer cleared. rst asserted mid-turn aborts immediately, including pending pulses.

## Timing
- All outputs are registered.
- flip_req accepted at edge k: reveal high in cycle k+1, phase=CHECK in cycle k+1.
- match_valid at edge k: move_req or phase=SHOW_MISS in cycle k+1.
- SHOW_MISS occupies exactly SHOW_CYCLES cycles; ADVANCE follows in the next cycle.
- turn_pulse and hide_all are high for exactly 1 cycle, in the same cycle. The new cur_player is visible in the cycle after turn_pulse.
- move_done with win=1: winner_valid high from the next cycle until start or rst.

## Configuration
- TURN_SEQ_TIMEOUT_EN defined: a timer restarts on entry to WAIT_FLIP. If no accepted flip occurs within TIMEOUT_CYCLES cycles, the FSM goes to ADVANCE and the turn passes to the next player.
- TURN_SEQ_TIMEOUT_EN undefined: WAIT_FLIP waits indefinitely; no timeout logic is synthesized.

## Structure
- Shared package game_pkg: state codes, NUM_TILES, player-id width (2), MAX_PLAYERS=4, MIN_PLAYERS=2.
- Sub-module cycle_timer: loadable down-counter with a done flag, shared by SHOW_MISS and the timeout feature.

## Test plan
- num_players=3, SHOW_CYCLES=4; three consecutive misses -> cur_player sequence 0→1→2→0; turn_pulse 1 cycle each; SHOW_MISS lasts 4 cycles.
- flip tile 5 with match=1, then move_done win=0, then flip tile 5 again -> second flip ignored, revealed=0x020, phase stays 1.
- num_players=7 then start -> N clamps to 4; four turn advances return cur_player to 0.
- Player 2 of 4: match=1, move_done with win=1 -> phase=6, winner=2, winner_valid=1. A later start resets cur_player=0 and winner_valid=0.
- rst asserted during SHOW_MISS -> next cycle phase=0, all outputs 0, no turn_pulse emitted.
- With TURN_SEQ_TIMEOUT_EN defined and TIMEOUT_CYCLES=10: no flip for 10 cycles -> ADVANCE, cur_player 0→1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the Chicken Cha-Cha-Cha game-flow logic: state codes,
// board size and player-count limits.
package game_pkg;

  localparam int unsigned NUM_TILES   = 12;
  localparam int unsigned TILE_IDX_W  = 4;
  localparam int unsigned PLAYER_W    = 2;
  localparam int unsigned MAX_PLAYERS = 4;
  localparam int unsigned MIN_PLAYERS = 2;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitFlip = 3'd1,
    StCheck    = 3'd2,
    StMove     = 3'd3,
    StShowMiss = 3'd4,
    StAdvance  = 3'd5,
    StDone     = 3'd6
  } state_e;

  function automatic logic [2:0] clamp_players(logic [2:0] n);
    if (n < 3'(MIN_PLAYERS)) begin
      return 3'(MIN_PLAYERS);
    end else if (n > 3'(MAX_PLAYERS)) begin
      return 3'(MAX_PLAYERS);
    end
    return n;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done_o flags the last counted cycle (count of 1) or an
// expired count.
module cycle_timer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q <= Width'(1));

endmodule

// File: rtl/turn_sequencer.sv
// Game-flow controller: sequences reveal, match check, chicken move and miss display per turn.
// Define TURN_SEQ_TIMEOUT_EN to pass the turn after TIMEOUT_CYCLES without an accepted flip.
module turn_sequencer
  import game_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES    = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           num_players,
  input  logic                 start,
  input  logic                 flip_req,
  input  logic [3:0]           flip_idx,
  input  logic                 match_valid,
  input  logic                 match,
  input  logic                 move_done,
  input  logic                 win,
  output logic [1:0]           cur_player,
  output logic                 reveal,
  output logic [3:0]           reveal_idx,
  output logic [NUM_TILES-1:0] revealed,
  output logic                 move_req,
  output logic                 hide_all,
  output logic                 turn_pulse,
  output logic [2:0]           phase,
  output logic                 winner_valid,
  output logic [1:0]           winner
);

  localparam int unsigned TimerMax = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [TILE_IDX_W-1:0] NumTilesIdx = TILE_IDX_W'(NUM_TILES);

  state_e                  state_q, state_d;
  logic [1:0]              cur_q, cur_d;
  logic [2:0]              n_q, n_d;
  logic                    reveal_q, reveal_d;
  logic [3:0]              reveal_idx_q, reveal_idx_d;
  logic [NUM_TILES-1:0]    revealed_q, revealed_d;
  logic                    move_req_q, move_req_d;
  logic                    hide_q, hide_d;
  logic                    turn_q, turn_d;
  logic                    winner_valid_q, winner_valid_d;
  logic [1:0]              winner_q, winner_d;

  logic                    tmr_load, tmr_en, tmr_done;
  logic [TimerW-1:0]       tmr_val;
  logic                    flip_ok;

  // Out-of-range indices are rejected before the mask bit matters.
  assign flip_ok = flip_req && (flip_idx < NumTilesIdx) && !revealed_q[flip_idx];

  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    n_d            = n_q;
    reveal_d       = 1'b0;
    reveal_idx_d   = reveal_idx_q;
    revealed_d     = revealed_q;
    move_req_d     = 1'b0;
    hide_d         = 1'b0;
    turn_d         = 1'b0;
    winner_valid_d = winner_valid_q;
    winner_d       = winner_q;
    tmr_load       = 1'b0;
    tmr_val        = TimerW'(SHOW_CYCLES);
    tmr_en         = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          n_d            = clamp_players(num_players);
          cur_d          = '0;
          revealed_d     = '0;
          winner_valid_d = 1'b0;
          state_d        = StWaitFlip;
        end
      end
      StWaitFlip: begin
`ifdef TURN_SEQ_TIMEOUT_EN
        tmr_en = 1'b1;
`endif
        if (&revealed_q) begin
          state_d = StAdvance;
        end else if (flip_ok) begin
          reveal_d               = 1'b1;
          reveal_idx_d           = flip_idx;
          revealed_d[flip_idx]   = 1'b1;
          state_d                = StCheck;
`ifdef TURN_SEQ_TIMEOUT_EN
        end else if (tmr_done) begin
          state_d = StAdvance;
`endif
        end
      end
      StCheck: begin
        if (match_valid) begin
          if (match) begin
            move_req_d = 1'b1;
            state_d    = StMove;
          end else begin
            tmr_load = 1'b1;
            state_d  = StShowMiss;
          end
        end
      end
      StMove: begin
        if (move_done) begin
          if (win) begin
            winner_d       = cur_q;
            winner_valid_d = 1'b1;
            state_d        = StDone;
          end else begin
            state_d = StWaitFlip;
          end
        end
      end
      StShowMiss: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_d = StAdvance;
        end
      end
      StAdvance: begin
        cur_d   = ({1'b0, cur_q} == (n_q - 3'd1)) ? 2'd0 : cur_q + 2'd1;
        state_d = StWaitFlip;
      end
      default: state_d = StIdle;
    endcase

    // Registered strobes must coincide with the ADVANCE cycle, so raise them on entry.
    if (state_d == StAdvance && state_q != StAdvance) begin
      hide_d     = 1'b1;
      turn_d     = 1'b1;
      revealed_d = '0;
    end

`ifdef TURN_SEQ_TIMEOUT_EN
    if (state_d == StWaitFlip && state_q != StWaitFlip) begin
      tmr_load = 1'b1;
      tmr_val  = TimerW'(TIMEOUT_CYCLES);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cur_q          <= '0;
      n_q            <= 3'(MIN_PLAYERS);
      reveal_q       <= 1'b0;
      reveal_idx_q   <= '0;
      revealed_q     <= '0;
      move_req_q     <= 1'b0;
      hide_q         <= 1'b0;
      turn_q         <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_q       <= '0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      n_q            <= n_d;
      reveal_q       <= reveal_d;
      reveal_idx_q   <= reveal_idx_d;
      revealed_q     <= revealed_d;
      move_req_q     <= move_req_d;
      hide_q         <= hide_d;
      turn_q         <= turn_d;
      winner_valid_q <= winner_valid_d;
      winner_q       <= winner_d;
    end
  end

  cycle_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  assign cur_player   = cur_q;
  assign reveal       = reveal_q;
  assign reveal_idx   = reveal_idx_q;
  assign revealed     = revealed_q;
  assign move_req     = move_req_q;
  assign hide_all     = hide_q;
  assign turn_pulse   = turn_q;
  assign phase        = state_q;
  assign winner_valid = winner_valid_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed self-checking bench for turn_sequencer with SHOW_CYCLES=4 and TIMEOUT_CYCLES=10.
module tb_turn_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  num_players = '0;
  logic        start = 1'b0;
  logic        flip_req = 1'b0;
  logic [3:0]  flip_idx = '0;
  logic        match_valid = 1'b0;
  logic        match = 1'b0;
  logic        move_done = 1'b0;
  logic        win = 1'b0;
  logic [1:0]  cur_player;
  logic        reveal;
  logic [3:0]  reveal_idx;
  logic [11:0] revealed;
  logic        move_req;
  logic        hide_all;
  logic        turn_pulse;
  logic [2:0]  phase;
  logic        winner_valid;
  logic [1:0]  winner;

  int n_checks = 0;
  int n_fail   = 0;

  turn_sequencer #(
    .SHOW_CYCLES    (4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .num_players  (num_players),
    .start        (start),
    .flip_req     (flip_req),
    .flip_idx     (flip_idx),
    .match_valid  (match_valid),
    .match        (match),
    .move_done    (move_done),
    .win          (win),
    .cur_player   (cur_player),
    .reveal       (reveal),
    .reveal_idx   (reveal_idx),
    .revealed     (revealed),
    .move_req     (move_req),
    .hide_all     (hide_all),
    .turn_pulse   (turn_pulse),
    .phase        (phase),
    .winner_valid (winner_valid),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] n);
    num_players = n;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_phase", 32'(phase), 32'd1);
    check_eq("start_cur", 32'(cur_player), 32'd0);
    check_eq("start_winner_valid", 32'(winner_valid), 32'd0);
  endtask

  task automatic do_flip(input logic [3:0] idx);
    flip_req = 1'b1;
    flip_idx = idx;
    step();
    flip_req = 1'b0;
    check_eq("flip_phase", 32'(phase), 32'd2);
    check_eq("flip_reveal", 32'(reveal), 32'd1);
    check_eq("flip_reveal_idx", 32'(reveal_idx), 32'(idx));
  endtask

  task automatic miss_turn(input logic [1:0] exp_next);
    int cnt;
    do_flip(4'd0);
    match_valid = 1'b1;
    match = 1'b0;
    step();
    match_valid = 1'b0;
    check_eq("miss_phase", 32'(phase), 32'd4);
    cnt = 0;
    while (phase == 3'd4 && cnt < 20) begin
      cnt++;
      step();
    end
    check_eq("miss_show_cycles", 32'(cnt), 32'd4);
    check_eq("adv_phase", 32'(phase), 32'd5);
    check_eq("adv_turn_pulse", 32'(turn_pulse), 32'd1);
    check_eq("adv_hide_all", 32'(hide_all), 32'd1);
    step();
    check_eq("post_adv_turn_pulse", 32'(turn_pulse), 32'd0);
    check_eq("post_adv_hide_all", 32'(hide_all), 32'd0);
    check_eq("post_adv_cur", 32'(cur_player), 32'(exp_next));
    check_eq("post_adv_revealed", 32'(revealed), 32'd0);
    check_eq("post_adv_phase", 32'(phase), 32'd1);
  endtask

  task automatic match_turn(input logic [3:0] idx, input logic w);
    do_flip(idx);
    match_valid = 1'b1;
    match = 1'b1;
    step();
    match_valid = 1'b0;
    match = 1'b0;
    check_eq("match_move_req", 32'(move_req), 32'd1);
    check_eq("match_phase", 32'(phase), 32'd3);
    move_done = 1'b1;
    win = w;
    step();
    move_done = 1'b0;
    win = 1'b0;
    check_eq("move_move_req", 32'(move_req), 32'd0);
  endtask

  initial begin
    logic seen_bad;
    int   cnt;

    #1;
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_outputs", {cur_player, reveal, reveal_idx, revealed, move_req, hide_all,
                             turn_pulse, winner_valid, winner}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check_eq("idle_phase", 32'(phase), 32'd0);

    // Three misses with three players.
    do_start(3'd3);
    miss_turn(2'd1);
    miss_turn(2'd2);
    miss_turn(2'd0);

    // Re-flip of an already face-up tile, and an out-of-range index, are ignored.
    match_turn(4'd5, 1'b0);
    check_eq("same_player_phase", 32'(phase), 32'd1);
    check_eq("same_player_revealed", 32'(revealed), 32'h020);
    flip_req = 1'b1;
    flip_idx = 4'd5;
    step();
    check_eq("reflip_phase", 32'(phase), 32'd1);
    check_eq("reflip_reveal", 32'(reveal), 32'd0);
    check_eq("reflip_revealed", 32'(revealed), 32'h020);
    flip_idx = 4'd12;
    step();
    flip_req = 1'b0;
    check_eq("badidx_phase", 32'(phase), 32'd1);
    check_eq("badidx_revealed", 32'(revealed), 32'h020);

    // Player 0 wins; start is ignored mid-game but restarts from DONE.
    match_turn(4'd6, 1'b1);
    check_eq("win0_phase", 32'(phase), 32'd6);
    check_eq("win0_winner", 32'(winner), 32'd0);
    check_eq("win0_valid", 32'(winner_valid), 32'd1);

    // Seven players clamp to four.
    do_start(3'd7);
    miss_turn(2'd1);
    miss_turn(2'd2);
    miss_turn(2'd3);
    miss_turn(2'd0);
    num_players = 3'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_ignored_phase", 32'(phase), 32'd1);
    miss_turn(2'd1);
    miss_turn(2'd2);
    match_turn(4'd3, 1'b1);
    check_eq("win2_phase", 32'(phase), 32'd6);
    check_eq("win2_winner", 32'(winner), 32'd2);
    check_eq("win2_valid", 32'(winner_valid), 32'd1);
    step();
    check_eq("win2_valid_hold", 32'(winner_valid), 32'd1);
    check_eq("win2_phase_hold", 32'(phase), 32'd6);

    // Zero players clamp to two; all tiles face-up forces ADVANCE.
    do_start(3'd0);
    for (int i = 0; i < 12; i++) begin
      match_turn(4'(i), 1'b0);
    end
    check_eq("full_revealed", 32'(revealed), 32'hfff);
    check_eq("full_phase", 32'(phase), 32'd1);
    step();
    check_eq("full_adv_phase", 32'(phase), 32'd5);
    check_eq("full_adv_pulse", 32'(turn_pulse), 32'd1);
    step();
    check_eq("full_next_cur", 32'(cur_player), 32'd1);
    check_eq("full_next_revealed", 32'(revealed), 32'd0);
    miss_turn(2'd0);

    // Asynchronous reset during SHOW_MISS.
    do_flip(4'd2);
    match_valid = 1'b1;
    step();
    match_valid = 1'b0;
    check_eq("pre_rst_phase", 32'(phase), 32'd4);
    step();
    rst = 1'b1;
    #1;
    check_eq("async_rst_phase", 32'(phase), 32'd0);
    check_eq("async_rst_outputs", {cur_player, reveal, reveal_idx, revealed, move_req, hide_all,
                                   turn_pulse, winner_valid, winner}, 32'd0);
    step();
    rst = 1'b0;
    seen_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (turn_pulse !== 1'b0 || phase !== 3'd0) seen_bad = 1'b1;
    end
    check_eq("rst_no_pulse", 32'(seen_bad), 32'd0);

`ifdef TURN_SEQ_TIMEOUT_EN
    do_start(3'd2);
    cnt = 0;
    while (phase == 3'd1 && cnt < 50) begin
      cnt++;
      step();
    end
    check_eq("timeout_cycles", 32'(cnt), 32'd10);
    check_eq("timeout_adv_pulse", 32'(turn_pulse), 32'd1);
    step();
    check_eq("timeout_next_cur", 32'(cur_player), 32'd1);
`else
    cnt = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
